rs_cdb_multi: RTL and testbench
===============================

Name: rs_cdb_multi

Overview:
- Parametrised reservation station for the out-of-order RISC-V core, fed by the decoder/dispatch stage and issuing to one integer ALU.
- Holds RS_SIZE entries with renamed source operands (value or ROB tag).
- Snoops NUM_CDB common-data-bus channels every cycle to wake operands.
- Issues one ready entry per cycle to the ALU with a valid/stall handshake; supports pipeline flush.

Parameters:
- ROB_WIDTH, 4, width of ROB tags.
- RS_SIZE, 8, number of entries (power of two, 2..32).
- NUM_CDB, 2, number of CDB broadcast channels snooped per cycle (1..4).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; asynchronous, active-low.
- rdy_in  input  1  global ready; low freezes all state.
- clear  input  1  flush (branch mispredict); synchronous.
- from_decoder  input  1  dispatch valid.
- from_decoder_op  input  6  opcode (ADD..LUI encoding).
- from_decoder_tag  input  ROB_WIDTH  destination ROB tag.
- from_decoder_imm  input  32  immediate.
- from_decoder_pc  input  32  instruction PC.
- from_decoder_vj / from_decoder_vk  input  32  source values from reg file/ROB.
- from_decoder_qj / from_decoder_qk  input  ROB_WIDTH  producer tags.
- from_decoder_qj_busy / from_decoder_qk_busy  input  1  1 = operand pending on tag.
- cdb_valid  input  NUM_CDB  per-channel broadcast valid.
- cdb_tag  input  NUM_CDB*ROB_WIDTH  packed tags; channel i at [i*ROB_WIDTH +: ROB_WIDTH].
- cdb_value  input  NUM_CDB*32  packed results.
- alu_stall  input  1  ALU cannot accept this cycle.
- rs_full  output  1  no free entry.
- to_alu_valid  output  1  issue valid.
- to_alu_op  output  6  opcode.
- to_alu_a / to_alu_b  output  32  operands (Vj, Vk).
- to_alu_imm / to_alu_pc  output  32  immediate, PC.
- to_alu_tag  output  ROB_WIDTH  destination tag.

Behaviour:
- Reset (rst_in=0, async): all entries invalid; every output 0; rs_full=0.
- rdy_in=0: no state change.
  - Dispatch and CDB inputs are ignored.
  - Issue registers hold their value.
- Entry fields: busy, op, tag, imm, pc, vj, vk, qj, qk, qj_busy, qk_busy.
- rs_full: combinational; 1 iff all entries are busy.
  - A dispatch while rs_full=1 is dropped; the decoder must not do this.
- Dispatch (from_decoder=1, not full): writes the lowest-index free entry at the next edge.
- Wakeup: each cycle, every busy entry with a pending operand compares its tag against all valid CDB channels.
  - On a match: capture the value and clear the busy bit at the edge.
  - If several channels match, the lowest channel index wins; a legal ROB never does this.
- Dispatch bypass: a dispatched operand whose tag matches a CDB channel in the same cycle is written already resolved, with the CDB value.
- Ready: busy && !qj_busy && !qk_busy, evaluated on registered state.
  - An entry woken this cycle is eligible for issue next cycle.
- Select/issue: if alu_stall=0, the lowest-index ready entry is latched into the to_alu_* registers with to_alu_valid=1, and that entry is freed at the same edge.
  - Latency: dispatch-with-ready-operands to to_alu_valid is 2 edges.
  - If no entry is ready, to_alu_valid goes to 0.
- alu_stall=1: to_alu_* hold their values (including valid); no entry is freed.
- A freed slot becomes usable for dispatch on the next cycle, not the same one.
- clear=1 (rdy_in=1): all entries invalidated and to_alu_valid=0 at the next edge.
  - Same-cycle dispatch and wakeup are discarded.
  - clear has priority over every other event.
- Wrap: none; allocation is purely by free-slot priority.
  - Entry age is not tracked; fairness comes from the freed entries.

Decomposition:
- Shared package/header `rv_defs`: opcode `defines (ADD..LUI), XLEN=32.
- Sub-module `prio_enc` (parametrised, lowest-index-first one-hot plus binary index).
  - Instantiated twice: free-slot pick and ready pick.
- CDB comparison stays inline as a generate loop.

Test Plan:
- Reset then dispatch ADD, tag=3, vj=5, vk=7, no busy bits.
  - Expect to_alu_valid=1, op=ADD, a=5, b=7, tag=3 two edges after dispatch.
- Dispatch SUB with qj_busy=1, qj=2, vk=1.
  - Next cycle drive cdb_valid[1]=1, tag=2, value=0x10.
  - Expect issue a=0x10, b=1 exactly two edges after the broadcast.
- Dispatch with qk=4 busy while cdb channel 0 broadcasts tag 4 = 0xAB in the same cycle.
  - Expect the entry to issue with b=0xAB without waiting for another broadcast.
- Fill all RS_SIZE entries pending on tag 9.
  - Expect rs_full=1 and a further dispatch dropped.
  - Broadcast tag 9: expect issues in index order 0..7, one per cycle; rs_full drops after the first issue.
- Hold alu_stall=1 for 3 cycles with 2 ready entries.
  - Expect to_alu_* stable and the entries retained; after release, issue proceeds in order.
- With 5 busy entries, assert clear for one cycle alongside a dispatch.
  - Expect rs_full=0, to_alu_valid=0, and no later issues.
- Also: async reset mid-issue clears outputs immediately; rdy_in=0 freezes state.

Source files
------------

// File: rtl/rs_cdb_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs_cdb_multi_pkg : shared datapath width, ALU opcodes, entry payload   |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package rs_cdb_multi_pkg;

  localparam int XLEN = 32;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_SLL  = 6'd6,
    OP_SRL  = 6'd7,
    OP_SRA  = 6'd8,
    OP_SLT  = 6'd9,
    OP_SLTU = 6'd10,
    OP_ADDI = 6'd11,
    OP_LUI  = 6'd12
  } alu_op_e;

  // Fields that never change between dispatch and issue.
  typedef struct packed {
    logic [5:0]      op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } rs_payload_t;

endpackage
`default_nettype wire

// File: rtl/rs_cdb_multi_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs_cdb_multi_prio_enc : lowest-index-first priority encoder            |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module rs_cdb_multi_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // Scanning downward lets the lowest requester overwrite any higher one.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IDX_W'(i);
        o_any       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_cdb_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs_cdb_multi : reservation station with multi-channel CDB wakeup       |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module rs_cdb_multi
  import rs_cdb_multi_pkg::*;
#(
  parameter int ROB_WIDTH = 4,
  parameter int RS_SIZE   = 8,
  parameter int NUM_CDB   = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clear,
  input  logic                         from_decoder,
  input  logic [5:0]                   from_decoder_op,
  input  logic [ROB_WIDTH-1:0]         from_decoder_tag,
  input  logic [XLEN-1:0]              from_decoder_imm,
  input  logic [XLEN-1:0]              from_decoder_pc,
  input  logic [XLEN-1:0]              from_decoder_vj,
  input  logic [XLEN-1:0]              from_decoder_vk,
  input  logic [ROB_WIDTH-1:0]         from_decoder_qj,
  input  logic [ROB_WIDTH-1:0]         from_decoder_qk,
  input  logic                         from_decoder_qj_busy,
  input  logic                         from_decoder_qk_busy,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
  input  logic                         alu_stall,
  output logic                         rs_full,
  output logic                         to_alu_valid,
  output logic [5:0]                   to_alu_op,
  output logic [XLEN-1:0]              to_alu_a,
  output logic [XLEN-1:0]              to_alu_b,
  output logic [XLEN-1:0]              to_alu_imm,
  output logic [XLEN-1:0]              to_alu_pc,
  output logic [ROB_WIDTH-1:0]         to_alu_tag
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]   r_busy;
  logic [RS_SIZE-1:0]   r_qj_busy;
  logic [RS_SIZE-1:0]   r_qk_busy;
  rs_payload_t          r_pay [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_tag [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qj  [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qk  [RS_SIZE];
  logic [XLEN-1:0]      r_vj  [RS_SIZE];
  logic [XLEN-1:0]      r_vk  [RS_SIZE];

  logic [RS_SIZE-1:0]   w_ready;
  logic [RS_SIZE-1:0]   w_j_hit;
  logic [RS_SIZE-1:0]   w_k_hit;
  logic [XLEN-1:0]      w_j_val [RS_SIZE];
  logic [XLEN-1:0]      w_k_val [RS_SIZE];
  logic [RS_SIZE-1:0]   w_free_oh;
  logic [RS_SIZE-1:0]   w_rdy_oh;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_rdy_idx;
  logic                 w_free_any;
  logic                 w_rdy_any;
  logic                 w_disp;
  logic                 w_issue;
  logic                 w_dj_hit;
  logic                 w_dk_hit;
  logic [XLEN-1:0]      w_dj_val;
  logic [XLEN-1:0]      w_dk_val;

  assign rs_full = &r_busy;

  for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_wake
    logic            w_jh;
    logic            w_kh;
    logic [XLEN-1:0] w_jv;
    logic [XLEN-1:0] w_kv;

    always_comb begin
      w_jh = 1'b0;
      w_kh = 1'b0;
      w_jv = '0;
      w_kv = '0;
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (cdb_valid[c] && (cdb_tag[c*ROB_WIDTH +: ROB_WIDTH] == r_qj[gi])) begin
          w_jh = 1'b1;
          w_jv = cdb_value[c*XLEN +: XLEN];
        end
        if (cdb_valid[c] && (cdb_tag[c*ROB_WIDTH +: ROB_WIDTH] == r_qk[gi])) begin
          w_kh = 1'b1;
          w_kv = cdb_value[c*XLEN +: XLEN];
        end
      end
    end

    assign w_j_hit[gi] = r_busy[gi] & r_qj_busy[gi] & w_jh;
    assign w_k_hit[gi] = r_busy[gi] & r_qk_busy[gi] & w_kh;
    assign w_j_val[gi] = w_jv;
    assign w_k_val[gi] = w_kv;
    assign w_ready[gi] = r_busy[gi] & ~r_qj_busy[gi] & ~r_qk_busy[gi];
  end

  // Same-cycle bypass for operands arriving with the dispatch.
  always_comb begin
    w_dj_hit = 1'b0;
    w_dk_hit = 1'b0;
    w_dj_val = '0;
    w_dk_val = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid[c] && (cdb_tag[c*ROB_WIDTH +: ROB_WIDTH] == from_decoder_qj)) begin
        w_dj_hit = from_decoder_qj_busy;
        w_dj_val = cdb_value[c*XLEN +: XLEN];
      end
      if (cdb_valid[c] && (cdb_tag[c*ROB_WIDTH +: ROB_WIDTH] == from_decoder_qk)) begin
        w_dk_hit = from_decoder_qk_busy;
        w_dk_val = cdb_value[c*XLEN +: XLEN];
      end
    end
  end

  rs_cdb_multi_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_pick (
    .i_req    (~r_busy),
    .o_onehot (w_free_oh),
    .o_idx    (w_free_idx),
    .o_any    (w_free_any)
  );

  rs_cdb_multi_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_rdy_pick (
    .i_req    (w_ready),
    .o_onehot (w_rdy_oh),
    .o_idx    (w_rdy_idx),
    .o_any    (w_rdy_any)
  );

  assign w_disp  = from_decoder & w_free_any;
  assign w_issue = ~alu_stall & w_rdy_any;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy       <= '0;
      r_qj_busy    <= '0;
      r_qk_busy    <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_pay[i] <= '0;
        r_tag[i] <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
      end
      to_alu_valid <= 1'b0;
      to_alu_op    <= '0;
      to_alu_a     <= '0;
      to_alu_b     <= '0;
      to_alu_imm   <= '0;
      to_alu_pc    <= '0;
      to_alu_tag   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_busy       <= '0;
        to_alu_valid <= 1'b0;
      end else begin
        r_busy <= (r_busy & ~(w_issue ? w_rdy_oh : '0)) | (w_disp ? w_free_oh : '0);

        for (int i = 0; i < RS_SIZE; i++) begin
          if (w_j_hit[i]) begin
            r_vj[i]      <= w_j_val[i];
            r_qj_busy[i] <= 1'b0;
          end
          if (w_k_hit[i]) begin
            r_vk[i]      <= w_k_val[i];
            r_qk_busy[i] <= 1'b0;
          end
        end

        // The free slot is never busy, so it cannot collide with a wakeup.
        if (w_disp) begin
          r_pay[w_free_idx]     <= '{op: from_decoder_op, imm: from_decoder_imm, pc: from_decoder_pc};
          r_tag[w_free_idx]     <= from_decoder_tag;
          r_qj[w_free_idx]      <= from_decoder_qj;
          r_qk[w_free_idx]      <= from_decoder_qk;
          r_vj[w_free_idx]      <= w_dj_hit ? w_dj_val : from_decoder_vj;
          r_vk[w_free_idx]      <= w_dk_hit ? w_dk_val : from_decoder_vk;
          r_qj_busy[w_free_idx] <= from_decoder_qj_busy & ~w_dj_hit;
          r_qk_busy[w_free_idx] <= from_decoder_qk_busy & ~w_dk_hit;
        end

        if (!alu_stall) begin
          to_alu_valid <= w_rdy_any;
          if (w_rdy_any) begin
            to_alu_op  <= r_pay[w_rdy_idx].op;
            to_alu_imm <= r_pay[w_rdy_idx].imm;
            to_alu_pc  <= r_pay[w_rdy_idx].pc;
            to_alu_a   <= r_vj[w_rdy_idx];
            to_alu_b   <= r_vk[w_rdy_idx];
            to_alu_tag <= r_tag[w_rdy_idx];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_cdb_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rs_cdb_multi : directed table, corner sequences, random vs model    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_rs_cdb_multi;
  import rs_cdb_multi_pkg::*;

  localparam int RW = 4;
  localparam int RS = 8;
  localparam int NC = 2;

  logic              clk_in, rst_in, rdy_in, clear, from_decoder;
  logic [5:0]        from_decoder_op;
  logic [RW-1:0]     from_decoder_tag, from_decoder_qj, from_decoder_qk;
  logic [31:0]       from_decoder_imm, from_decoder_pc, from_decoder_vj, from_decoder_vk;
  logic              from_decoder_qj_busy, from_decoder_qk_busy;
  logic [NC-1:0]     cdb_valid;
  logic [NC*RW-1:0]  cdb_tag;
  logic [NC*32-1:0]  cdb_value;
  logic              alu_stall;
  logic              rs_full, to_alu_valid;
  logic [5:0]        to_alu_op;
  logic [31:0]       to_alu_a, to_alu_b, to_alu_imm, to_alu_pc;
  logic [RW-1:0]     to_alu_tag;

  int n_cmp;
  int n_bad;

  rs_cdb_multi #(.ROB_WIDTH(RW), .RS_SIZE(RS), .NUM_CDB(NC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .from_decoder(from_decoder), .from_decoder_op(from_decoder_op),
    .from_decoder_tag(from_decoder_tag), .from_decoder_imm(from_decoder_imm),
    .from_decoder_pc(from_decoder_pc), .from_decoder_vj(from_decoder_vj),
    .from_decoder_vk(from_decoder_vk), .from_decoder_qj(from_decoder_qj),
    .from_decoder_qk(from_decoder_qk), .from_decoder_qj_busy(from_decoder_qj_busy),
    .from_decoder_qk_busy(from_decoder_qk_busy), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_value(cdb_value), .alu_stall(alu_stall),
    .rs_full(rs_full), .to_alu_valid(to_alu_valid), .to_alu_op(to_alu_op),
    .to_alu_a(to_alu_a), .to_alu_b(to_alu_b), .to_alu_imm(to_alu_imm),
    .to_alu_pc(to_alu_pc), .to_alu_tag(to_alu_tag)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic logic [31:0] imm_of(input logic [RW-1:0] t);
    return 32'h100 + {28'd0, t};
  endfunction

  function automatic logic [31:0] pc_of(input logic [RW-1:0] t);
    return 32'h4000 + {26'd0, t, 2'b00};
  endfunction

  task automatic expect_issue(input string nm, input logic [5:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [RW-1:0] t);
    chk1({nm, ".valid"}, to_alu_valid, 1'b1);
    chk32({nm, ".op"}, {26'd0, to_alu_op}, {26'd0, op});
    chk32({nm, ".a"}, to_alu_a, a);
    chk32({nm, ".b"}, to_alu_b, b);
    chk32({nm, ".tag"}, {28'd0, to_alu_tag}, {28'd0, t});
    chk32({nm, ".imm"}, to_alu_imm, imm_of(t));
    chk32({nm, ".pc"}, to_alu_pc, pc_of(t));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in       = 1'b1;
    clear        = 1'b0;
    from_decoder = 1'b0;
    cdb_valid    = '0;
    alu_stall    = 1'b0;
  endtask

  task automatic drive_disp(input logic [5:0] op, input logic [RW-1:0] t,
                            input logic [31:0] vj, input logic [31:0] vk,
                            input logic jb, input logic [RW-1:0] qj,
                            input logic kb, input logic [RW-1:0] qk);
    from_decoder         = 1'b1;
    from_decoder_op      = op;
    from_decoder_tag     = t;
    from_decoder_imm     = imm_of(t);
    from_decoder_pc      = pc_of(t);
    from_decoder_vj      = vj;
    from_decoder_vk      = vk;
    from_decoder_qj_busy = jb;
    from_decoder_qj      = qj;
    from_decoder_qk_busy = kb;
    from_decoder_qk      = qk;
  endtask

  task automatic drive_cdb(input int ch, input logic [RW-1:0] t, input logic [31:0] v);
    cdb_valid[ch]          = 1'b1;
    cdb_tag[ch*RW +: RW]   = t;
    cdb_value[ch*32 +: 32] = v;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    chk1("reset.valid", to_alu_valid, 1'b0);
    chk1("reset.full", rs_full, 1'b0);
    chk32("reset.a", to_alu_a, 32'd0);
    chk32("reset.tag", {28'd0, to_alu_tag}, 32'd0);
    #3;
    rst_in = 1'b1;
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic          busy;
    logic [5:0]    op;
    logic [RW-1:0] tag;
    logic [31:0]   imm, pc, vj, vk;
    logic [RW-1:0] qj, qk;
    logic          jb, kb;
  } ment_t;

  ment_t         m_e [RS];
  logic          m_valid;
  logic [5:0]    m_op;
  logic [31:0]   m_a, m_b, m_imm, m_pc;
  logic [RW-1:0] m_tag;

  task automatic m_reset();
    for (int i = 0; i < RS; i++) m_e[i] = '{default: '0};
    m_valid = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_imm = '0; m_pc = '0; m_tag = '0;
  endtask

  // First valid channel carrying tag t, searching from channel 0 upward.
  function automatic logic cdb_find(input logic [RW-1:0] t, output logic [31:0] v);
    v = '0;
    for (int c = 0; c < NC; c++)
      if (cdb_valid[c] && cdb_tag[c*RW +: RW] == t) begin
        v = cdb_value[c*32 +: 32];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_step();
    ment_t       old [RS];
    int          r, f;
    logic [31:0] v;
    if (!rdy_in) return;
    if (clear) begin
      for (int i = 0; i < RS; i++) m_e[i].busy = 1'b0;
      m_valid = 1'b0;
      return;
    end
    old = m_e;
    r = -1;
    f = -1;
    for (int i = 0; i < RS; i++) begin
      if (r < 0 && old[i].busy && !old[i].jb && !old[i].kb) r = i;
      if (f < 0 && !old[i].busy) f = i;
    end
    for (int i = 0; i < RS; i++) begin
      if (old[i].busy && old[i].jb && cdb_find(old[i].qj, v)) begin m_e[i].vj = v; m_e[i].jb = 1'b0; end
      if (old[i].busy && old[i].kb && cdb_find(old[i].qk, v)) begin m_e[i].vk = v; m_e[i].kb = 1'b0; end
    end
    if (!alu_stall) begin
      m_valid = (r >= 0);
      if (r >= 0) begin
        m_op = old[r].op; m_a = old[r].vj; m_b = old[r].vk;
        m_imm = old[r].imm; m_pc = old[r].pc; m_tag = old[r].tag;
        m_e[r].busy = 1'b0;
      end
    end
    if (from_decoder && f >= 0) begin
      m_e[f] = '{busy: 1'b1, op: from_decoder_op, tag: from_decoder_tag,
                 imm: from_decoder_imm, pc: from_decoder_pc,
                 vj: from_decoder_vj, vk: from_decoder_vk,
                 qj: from_decoder_qj, qk: from_decoder_qk,
                 jb: from_decoder_qj_busy, kb: from_decoder_qk_busy};
      if (from_decoder_qj_busy && cdb_find(from_decoder_qj, v)) begin m_e[f].vj = v; m_e[f].jb = 1'b0; end
      if (from_decoder_qk_busy && cdb_find(from_decoder_qk, v)) begin m_e[f].vk = v; m_e[f].kb = 1'b0; end
    end
  endtask

  function automatic logic m_full();
    for (int i = 0; i < RS; i++) if (!m_e[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [5:0]    op;
    logic [RW-1:0] tag;
    logic [31:0]   vj, vk;
    logic          jb;
    logic [RW-1:0] qj;
    logic          kb;
    logic [RW-1:0] qk;
    logic          cv;
    logic [RW-1:0] ct;
    logic [31:0]   cval;
    logic [31:0]   ea, eb;
  } vec_t;

  vec_t vt [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_in = 1'b1;
    idle();
    drive_disp(6'd0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    from_decoder = 1'b0;
    cdb_tag   = '0;
    cdb_value = '0;

    vt[0] = '{OP_ADD, 4'd3,  32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd7};
    vt[1] = '{OP_SUB, 4'd1,  32'd9, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 4'd4, 32'hAB, 32'd9, 32'hAB};
    vt[2] = '{OP_XOR, 4'd2,  32'd0, 32'h77, 1'b1, 4'd6, 1'b0, 4'd0, 1'b1, 4'd6, 32'h123, 32'h123, 32'h77};
    vt[3] = '{OP_AND, 4'd5,  32'd0, 32'd0, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 4'd2, 32'h55, 32'h55, 32'h55};
    vt[4] = '{OP_OR,  4'd6,  32'd1, 32'd2, 1'b0, 4'd1, 1'b0, 4'd1, 1'b1, 4'd1, 32'hEE, 32'd1, 32'd2};
    vt[5] = '{OP_LUI, 4'd15, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,
              32'hFFFF_FFFF, 32'd0};

    do_reset();

    // Dispatch (with optional same-cycle bypass) reaches the ALU two edges later.
    for (int k = 0; k < 6; k++) begin
      drive_disp(vt[k].op, vt[k].tag, vt[k].vj, vt[k].vk, vt[k].jb, vt[k].qj, vt[k].kb, vt[k].qk);
      if (vt[k].cv) drive_cdb(0, vt[k].ct, vt[k].cval);
      tick();
      idle();
      chk1("tbl.early", to_alu_valid, 1'b0);
      tick();
      expect_issue("tbl", vt[k].op, vt[k].ea, vt[k].eb, vt[k].tag);
      tick();
      chk1("tbl.drain", to_alu_valid, 1'b0);
    end

    // Wakeup on channel 1 one cycle after dispatch.
    drive_disp(OP_SUB, 4'd8, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0);
    tick();
    idle();
    drive_cdb(1, 4'd2, 32'h10);
    tick();
    idle();
    chk1("wake.early", to_alu_valid, 1'b0);
    tick();
    expect_issue("wake", OP_SUB, 32'h10, 32'd1, 4'd8);

    // Fill every entry pending on tag 9, then drop an extra dispatch.
    tick();
    for (int k = 0; k < RS; k++) begin
      drive_disp(OP_ADD, RW'(k), 32'd0, 32'(k), 1'b1, 4'd9, 1'b0, 4'd0);
      tick();
    end
    chk1("full.set", rs_full, 1'b1);
    drive_disp(OP_ADD, 4'd15, 32'hDEAD, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    chk1("full.hold", rs_full, 1'b1);
    chk1("full.noissue", to_alu_valid, 1'b0);
    idle();
    drive_cdb(0, 4'd9, 32'h99);
    tick();
    idle();
    chk1("full.wake", to_alu_valid, 1'b0);
    for (int k = 0; k < RS; k++) begin
      tick();
      expect_issue("full.order", OP_ADD, 32'h99, 32'(k), RW'(k));
      if (k == 0) chk1("full.drop", rs_full, 1'b0);
    end
    tick();
    chk1("full.dropped", to_alu_valid, 1'b0);

    // Stall holds the issue registers and keeps the second entry.
    drive_disp(OP_ADD, 4'd1, 32'h11, 32'h12, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    drive_disp(OP_XOR, 4'd2, 32'h21, 32'h22, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    alu_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_issue("stall.hold", OP_ADD, 32'h11, 32'h12, 4'd1);
    end
    alu_stall = 1'b0;
    tick();
    expect_issue("stall.next", OP_XOR, 32'h21, 32'h22, 4'd2);
    tick();
    chk1("stall.drain", to_alu_valid, 1'b0);

    // Flush with five pending entries and a live issue.
    for (int k = 0; k < 5; k++) begin
      drive_disp(OP_SLT, RW'(k), 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd12);
      tick();
    end
    drive_disp(OP_ADD, 4'd6, 32'd6, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    expect_issue("clr.pre", OP_ADD, 32'd6, 32'd6, 4'd6);
    clear = 1'b1;
    drive_disp(OP_ADD, 4'd7, 32'd7, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    drive_cdb(0, 4'd12, 32'hC0);
    tick();
    idle();
    chk1("clr.full", rs_full, 1'b0);
    chk1("clr.valid", to_alu_valid, 1'b0);
    drive_cdb(1, 4'd12, 32'hC1);
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      chk1("clr.noissue", to_alu_valid, 1'b0);
    end
    for (int k = 0; k < RS; k++) begin
      drive_disp(OP_SLL, RW'(k), 32'd0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0);
      tick();
      if (k == RS - 2) chk1("clr.refill7", rs_full, 1'b0);
    end
    chk1("clr.refill8", rs_full, 1'b1);
    idle();
    clear = 1'b1;
    tick();
    idle();

    // rdy_in low freezes everything, including clear and dispatch.
    drive_disp(OP_ADD, 4'd3, 32'h31, 32'h32, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    drive_disp(OP_SUB, 4'd4, 32'h41, 32'h42, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    drive_disp(OP_OR, 4'd5, 32'h51, 32'h52, 1'b0, 4'd0, 1'b0, 4'd0);
    rdy_in = 1'b0;
    clear  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      expect_issue("rdy.freeze", OP_ADD, 32'h31, 32'h32, 4'd3);
    end
    idle();
    tick();
    expect_issue("rdy.resume", OP_SUB, 32'h41, 32'h42, 4'd4);
    tick();
    chk1("rdy.ignored", to_alu_valid, 1'b0);

    // Asynchronous reset in the middle of issuing.
    drive_disp(OP_ADD, 4'd8, 32'h81, 32'h82, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    drive_disp(OP_ADD, 4'd9, 32'h91, 32'h92, 1'b0, 4'd0, 1'b0, 4'd0);
    tick();
    idle();
    chk1("arst.pre", to_alu_valid, 1'b1);
    #2;
    rst_in = 1'b0;
    #1;
    chk1("arst.valid", to_alu_valid, 1'b0);
    chk32("arst.a", to_alu_a, 32'd0);
    chk32("arst.tag", {28'd0, to_alu_tag}, 32'd0);
    #2;
    rst_in = 1'b1;
    tick();
    chk1("arst.gone", to_alu_valid, 1'b0);

    // Random traffic against the reference.
    do_reset();
    m_reset();
    for (int n = 0; n < 1500; n++) begin
      rdy_in               = ($urandom_range(9) != 0);
      clear                = ($urandom_range(49) == 0);
      alu_stall            = ($urandom_range(3) == 0);
      from_decoder         = 1'($urandom_range(1));
      from_decoder_op      = 6'($urandom_range(12, 1));
      from_decoder_tag     = 4'($urandom_range(15));
      from_decoder_imm     = $urandom;
      from_decoder_pc      = $urandom;
      from_decoder_vj      = $urandom;
      from_decoder_vk      = $urandom;
      from_decoder_qj      = 4'($urandom_range(3));
      from_decoder_qk      = 4'($urandom_range(3));
      from_decoder_qj_busy = 1'($urandom_range(1));
      from_decoder_qk_busy = 1'($urandom_range(1));
      cdb_valid            = 2'($urandom_range(3));
      cdb_tag              = {4'($urandom_range(3)), 4'($urandom_range(3))};
      cdb_value            = {$urandom, $urandom};
      model_step();
      tick();
      chk1("rnd.valid", to_alu_valid, m_valid);
      chk32("rnd.op", {26'd0, to_alu_op}, {26'd0, m_op});
      chk32("rnd.a", to_alu_a, m_a);
      chk32("rnd.b", to_alu_b, m_b);
      chk32("rnd.imm", to_alu_imm, m_imm);
      chk32("rnd.pc", to_alu_pc, m_pc);
      chk32("rnd.tag", {28'd0, to_alu_tag}, {28'd0, m_tag});
      chk1("rnd.full", rs_full, m_full());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
